// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - LEGv8 5-stage pipeline stall/flush/freeze sequencer
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_is_reg_br,
  input  logic             id_is_blt,
  input  logic             id_br_taken,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_update_flags,
  input  logic [4:0]       mem_rd,
  input  logic             mem_mem_read,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             back_write,
  output logic             dmem_req,
  output logic             mem_wait,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MEM_TIMEOUT);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  logic [0:0]      state;
  logic [WC_W-1:0] wait_cnt;

  logic match_ex;
  logic match_mem;
  logic haz;
  logic freeze;

  // Hazard detection; X31 reads as zero so it never creates a dependency
  always_comb begin
    match_ex  = (ex_rd != 5'd31) &&
                ((id_use_rn && (id_rn == ex_rd)) || (id_use_rm && (id_rm == ex_rd)));
    match_mem = (mem_rd != 5'd31) &&
                ((id_use_rn && (id_rn == mem_rd)) || (id_use_rm && (id_rm == mem_rd)));
    haz = id_valid && (
            (ex_mem_read && match_ex) ||
            (id_is_reg_br && ex_reg_write && match_ex) ||
            (id_is_reg_br && mem_mem_read && match_mem) ||
            (id_is_blt && ex_update_flags));
    // Once the wait counter hits the limit the access is abandoned and the pipe is released
    freeze = mem_access && !dmem_ready && (wait_cnt != WAIT_MAX);
  end

  // Per-cycle pipeline register controls: reset, then freeze, then stall, then normal flow
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    back_write   = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    dmem_req     = mem_access;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      back_write   = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      dmem_req     = 1'b0;
    end else if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      back_write  = 1'b0;
    end else if (haz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      if_id_flush = id_valid && id_br_taken;
    end
  end

  assign mem_wait = (state == ST_MEM_WAIT);

  // Memory wait state machine with timeout and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (freeze) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        default: begin
          if (freeze) begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end else begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            if (mem_access && !dmem_ready) begin
              mem_error <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Saturating performance counters for stalled and flushed cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (if_id_flush && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_use_rn, id_use_rm, id_is_reg_br, id_is_blt, id_br_taken;
  logic [4:0] id_rn, id_rm, ex_rd, mem_rd;
  logic ex_reg_write, ex_mem_read, ex_update_flags;
  logic mem_mem_read, mem_access, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, back_write;
  logic dmem_req, mem_wait, mem_error;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_is_reg_br(id_is_reg_br), .id_is_blt(id_is_blt), .id_br_taken(id_br_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_update_flags(ex_update_flags),
    .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_access(mem_access),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .back_write(back_write),
    .dmem_req(dmem_req), .mem_wait(mem_wait), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
    id_is_reg_br = 0; id_is_blt = 0; id_br_taken = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_update_flags = 0;
    mem_rd = 0; mem_mem_read = 0; mem_access = 0; dmem_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    mem_access = 1;
    #1;
    check("rst_pc_write", pc_write, 0);
    check("rst_if_id_write", if_id_write, 0);
    check("rst_back_write", back_write, 0);
    check("rst_if_id_flush", if_id_flush, 1);
    check("rst_id_ex_bubble", id_ex_bubble, 1);
    check("rst_dmem_req", dmem_req, 0);
    tick();
    tick();
    reset = 0;
    idle();
    #1;
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_flush_count", flush_count, 0);
    check("rst_mem_error", mem_error, 0);
    check("rst_mem_wait", mem_wait, 0);
    check("idle_pc_write", pc_write, 1);

    // load-use: LDUR X1 in EX, ADDI reads X1
    id_valid = 1; id_use_rn = 1; id_rn = 1;
    ex_rd = 1; ex_mem_read = 1; ex_reg_write = 1;
    #1;
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_bubble", id_ex_bubble, 1);
    check("lu_back_write", back_write, 1);
    tick();
    ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0;
    mem_rd = 1; mem_mem_read = 1; mem_access = 1; dmem_ready = 1;
    #1;
    check("lu_advance", pc_write, 1);
    check("lu_bubble_off", id_ex_bubble, 0);
    check("lu_stall_cycles", stall_cycles, 1);
    tick();
    idle();
    // X31 destination never hazards
    id_valid = 1; id_use_rn = 1; id_rn = 31; ex_rd = 31; ex_mem_read = 1;
    #1;
    check("x31_no_stall", pc_write, 1);
    // rm path hazard, and rm ignored when not used
    idle();
    id_valid = 1; id_use_rm = 1; id_rm = 5; ex_rd = 5; ex_mem_read = 1;
    #1;
    check("rm_stall", pc_write, 0);
    id_use_rm = 0;
    #1;
    check("rm_unused", pc_write, 1);
    id_use_rm = 1; id_valid = 0; id_br_taken = 1;
    #1;
    check("invalid_no_stall", pc_write, 1);
    check("invalid_no_flush", if_id_flush, 0);
    id_valid = 1; id_br_taken = 0;
    tick();  // stall cycle, total 2
    idle();

    // CBZ X2 after LDUR X2: H1/H2 then H3
    id_valid = 1; id_is_reg_br = 1; id_use_rn = 1; id_rn = 2;
    ex_rd = 2; ex_mem_read = 1; ex_reg_write = 1;
    #1;
    check("cbz_stall1", pc_write, 0);
    tick();
    ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0;
    mem_rd = 2; mem_mem_read = 1; mem_access = 1;
    #1;
    check("cbz_stall2", pc_write, 0);
    check("cbz_stall2_bubble", id_ex_bubble, 1);
    tick();
    mem_rd = 0; mem_mem_read = 0; mem_access = 0; id_br_taken = 1;
    #1;
    check("cbz_go", pc_write, 1);
    check("cbz_flush", if_id_flush, 1);
    tick();
    idle();
    #1;
    check("cbz_flush_count", flush_count, 1);
    check("cbz_stall_cycles", stall_cycles, 4);
    check("cbz_flush_off", if_id_flush, 0);

    // CBZ after an ALU op stalls once, and MEM ALU result does not stall
    id_valid = 1; id_is_reg_br = 1; id_use_rn = 1; id_rn = 3;
    ex_rd = 3; ex_reg_write = 1;
    #1;
    check("cbz_alu_stall", pc_write, 0);
    tick();
    ex_rd = 0; ex_reg_write = 0; mem_rd = 3;
    #1;
    check("cbz_alu_go", pc_write, 1);
    tick();
    idle();

    // B.LT after SUBS
    id_valid = 1; id_is_blt = 1; id_br_taken = 1; ex_update_flags = 1;
    #1;
    check("blt_stall", pc_write, 0);
    check("blt_no_flush", if_id_flush, 0);
    tick();
    ex_update_flags = 0;
    #1;
    check("blt_flush", if_id_flush, 1);
    tick();
    idle();
    #1;
    check("blt_flush_count", flush_count, 2);
    check("blt_stall_cycles", stall_cycles, 6);

    // memory freeze: ready low 3 cycles then high
    mem_access = 1; dmem_ready = 0;
    #1;
    check("mw1_back_write", back_write, 0);
    check("mw1_pc_write", pc_write, 0);
    check("mw1_bubble", id_ex_bubble, 0);
    check("mw1_dmem_req", dmem_req, 1);
    check("mw1_mem_wait", mem_wait, 0);
    tick();
    id_valid = 1; id_is_blt = 1; ex_update_flags = 1;  // freeze outranks stall
    #1;
    check("mw2_mem_wait", mem_wait, 1);
    check("mw2_bubble", id_ex_bubble, 0);
    check("mw2_back_write", back_write, 0);
    tick();
    id_valid = 0; id_is_blt = 0; ex_update_flags = 0;
    #1;
    check("mw3_if_id_write", if_id_write, 0);
    tick();
    dmem_ready = 1;
    #1;
    check("mw4_back_write", back_write, 1);
    check("mw4_pc_write", pc_write, 1);
    check("mw4_mem_wait", mem_wait, 1);
    tick();
    idle();
    #1;
    check("mw_done_wait", mem_wait, 0);
    check("mw_no_error", mem_error, 0);
    check("mw_stall_cycles", stall_cycles, 9);

    // timeout: 4 frozen cycles, 5th forced release
    mem_access = 1; dmem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      check($sformatf("to_frozen%0d", i), back_write, 0);
      tick();
    end
    #1;
    check("to_release", back_write, 1);
    check("to_release_pc", pc_write, 1);
    check("to_err_not_yet", mem_error, 0);
    tick();
    #1;
    check("to_mem_error", mem_error, 1);
    check("to_mem_wait", mem_wait, 0);
    idle();
    tick();
    check("to_err_sticky", mem_error, 1);
    check("to_stall_cycles", stall_cycles, 13);

    // saturation: 4 more stall cycles would pass 15
    id_valid = 1; id_is_blt = 1; ex_update_flags = 1;
    for (int i = 0; i < 4; i++) tick();
    check("sat_stall_cycles", stall_cycles, 15);
    idle();

    // reset during second MEM_WAIT cycle
    mem_access = 1; dmem_ready = 0;
    tick();
    #1;
    check("rmw_in_wait", mem_wait, 1);
    reset = 1;
    #1;
    check("rmw_flush", if_id_flush, 1);
    check("rmw_bubble", id_ex_bubble, 1);
    check("rmw_dmem_req", dmem_req, 0);
    check("rmw_pc_write", pc_write, 0);
    tick();
    reset = 0;
    idle();
    #1;
    check("rmw_state", mem_wait, 0);
    check("rmw_stall", stall_cycles, 0);
    check("rmw_flush_count", flush_count, 0);
    check("rmw_mem_error", mem_error, 0);
    // wait counter restarted: a fresh access freezes again
    mem_access = 1; dmem_ready = 0;
    #1;
    check("rmw_refreeze", back_write, 0);
    tick();
    idle();
    #1;
    check("rmw_stall_after", stall_cycles, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
